// File: rtl/aes_key_expand_pkg.sv
// Shared AES key-schedule types, constants and helpers: S-box table, key length
// encoding, Nk/Nr lookups and the GF(2^8) doubling used for rcon.
package aes_key_expand_pkg;

  localparam int MAX_ROUNDS = 14;

  typedef enum logic [1:0] {
    KEY_128  = 2'd0,
    KEY_192  = 2'd1,
    KEY_256  = 2'd2,
    KEY_RSVD = 2'd3
  } key_len_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_GEN  = 2'd1
  } ke_state_e;

  // Entry 0 sits in the most significant byte so the table reads like the usual 16x16 grid.
  localparam logic [0:255][7:0] SUB_BYTES_TABLE = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [3:0] nk_of(key_len_e kl);
    case (kl)
      KEY_128: nk_of = 4'd4;
      KEY_192: nk_of = 4'd6;
      default: nk_of = 4'd8;
    endcase
  endfunction

  function automatic logic [3:0] nr_of(key_len_e kl);
    case (kl)
      KEY_128: nr_of = 4'd10;
      KEY_192: nr_of = 4'd12;
      default: nr_of = 4'd14;
    endcase
  endfunction

  function automatic int key_bits_of(key_len_e kl);
    case (kl)
      KEY_128: key_bits_of = 128;
      KEY_192: key_bits_of = 192;
      KEY_256: key_bits_of = 256;
      default: key_bits_of = 0;
    endcase
  endfunction

  function automatic logic [7:0] xtime(logic [7:0] r);
    xtime = {r[6:0], 1'b0} ^ (r[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sub_word.sv
// SubWord: four parallel S-box lookups on one 32-bit schedule word.
module aes_sub_word
  import aes_key_expand_pkg::*;
(
  input  logic [31:0] word_i,
  output logic [31:0] word_o
);

  always_comb begin
    word_o = '0;
    for (int k = 0; k < 4; k++) begin
      word_o[8*k +: 8] = SUB_BYTES_TABLE[word_i[8*k +: 8]];
    end
  end

endmodule

// File: rtl/aes_key_expand.sv
// AES key-schedule engine: one 32-bit schedule word per clock, round keys streamed
// forward on a valid/ready port and optionally kept in a store for reverse reads.
module aes_key_expand
  import aes_key_expand_pkg::*;
#(
  parameter int MAX_KEY_BITS = 256,
  parameter bit STORE_KEYS   = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MAX_KEY_BITS-1:0] key_in,
  input  logic [1:0]              key_len,
  input  logic                    start_valid,
  output logic                    start_ready,
  output logic                    rk_valid,
  input  logic                    rk_ready,
  output logic [127:0]            rk_data,
  output logic [3:0]              rk_idx,
  output logic                    rk_last,
  output logic                    busy,
  output logic                    keys_ready,
  output logic                    cfg_err,
  input  logic [3:0]              rd_idx,
  output logic [127:0]            rd_data,
  output logic [1:0]              dbg_state
);

  // Handshakes: a transfer happens on the rising clk edge where valid && ready are both 1;
  // once valid is raised the producer holds its payload stable until that edge.

  localparam int KEY_WORDS = MAX_KEY_BITS / 32;

  ke_state_e     state_q, state_d;
  logic [31:0]   key_w_q [8];
  logic [31:0]   key_words [8];
  logic [3:0]    nk_q, nr_q;
  logic [5:0]    i_q;
  logic [2:0]    j_q;
  logic [7:0]    rcon_q;
  logic [31:0]   win_q [8];
  logic [31:0]   col_q [3];
  logic [127:0]  out_data_q;
  logic [3:0]    out_idx_q;
  logic          out_last_q, out_valid_q;
  logic          keys_ready_q, cfg_err_q;

  key_len_e      req_len;
  logic          req_ok, accept, start_ready_w, busy_w;
  logic          gen_en, key_done, is_key_word, last_word, mid_sub, j_wrap;
  logic [31:0]   sub_in, sub_out, win_far, t_word, w_new;

  for (genvar g = 0; g < 8; g++) begin : g_key_words
    if (g < KEY_WORDS) begin : g_used
      assign key_words[g] = key_in[MAX_KEY_BITS-1-32*g -: 32];
    end else begin : g_pad
      assign key_words[g] = '0;
    end
  end

  assign req_len = key_len_e'(key_len);
  assign req_ok  = (req_len != KEY_RSVD) && (key_bits_of(req_len) <= MAX_KEY_BITS);
  assign accept  = start_valid && start_ready_w;

  // A complete round key needs the output register free (or draining this cycle).
  assign gen_en    = (state_q == ST_GEN) && ((i_q[1:0] != 2'b11) || !out_valid_q || rk_ready);
  assign key_done  = gen_en && (i_q[1:0] == 2'b11);
  assign last_word = (i_q == {nr_q, 2'b11});
  assign j_wrap    = ({1'b0, j_q} == (nk_q - 4'd1));

  // Schedule datapath: win_q[0] = w[i-1]; w[i-Nk] sits at Nk-1 (3-bit wrap maps Nk=8 to 7).
  assign is_key_word = (i_q < {2'b00, nk_q});
  assign mid_sub     = (nk_q == 4'd8) && (j_q == 3'd4);
  assign win_far     = win_q[nk_q[2:0] - 3'd1];
  assign sub_in      = (j_q == 3'd0) ? {win_q[0][23:0], win_q[0][31:24]} : win_q[0];

  aes_sub_word u_sub_word (
    .word_i (sub_in),
    .word_o (sub_out)
  );

  always_comb begin
    t_word = win_q[0];
    if (j_q == 3'd0) begin
      t_word = sub_out ^ {rcon_q, 24'h0};
    end else if (mid_sub) begin
      t_word = sub_out;
    end
    w_new = is_key_word ? key_w_q[i_q[2:0]] : (win_far ^ t_word);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept && req_ok) state_d = ST_GEN;
      ST_GEN:  if (gen_en && last_word) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // The last round key may still wait in the output register after the FSM is back in IDLE.
  always_comb begin
    start_ready_w = (state_q == ST_IDLE) && !out_valid_q;
    busy_w        = (state_q == ST_GEN);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 8; k++) begin
        key_w_q[k] <= '0;
        win_q[k]   <= '0;
      end
      for (int k = 0; k < 3; k++) col_q[k] <= '0;
      nk_q         <= '0;
      nr_q         <= '0;
      i_q          <= '0;
      j_q          <= '0;
      rcon_q       <= '0;
      out_data_q   <= '0;
      out_idx_q    <= '0;
      out_last_q   <= 1'b0;
      out_valid_q  <= 1'b0;
      keys_ready_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      cfg_err_q <= accept && !req_ok;
      if (accept && req_ok) begin
        for (int k = 0; k < 8; k++) key_w_q[k] <= key_words[k];
        nk_q         <= nk_of(req_len);
        nr_q         <= nr_of(req_len);
        i_q          <= '0;
        j_q          <= '0;
        rcon_q       <= 8'h01;
        keys_ready_q <= 1'b0;
      end
      if (gen_en) begin
        i_q <= i_q + 6'd1;
        j_q <= j_wrap ? 3'd0 : j_q + 3'd1;
        if (!is_key_word && (j_q == 3'd0)) rcon_q <= xtime(rcon_q);
        win_q[0] <= w_new;
        for (int k = 1; k < 8; k++) win_q[k] <= win_q[k-1];
        if (i_q[1:0] != 2'b11) col_q[i_q[1:0]] <= w_new;
        if (last_word) keys_ready_q <= 1'b1;
      end
      if (key_done) begin
        out_data_q  <= {col_q[0], col_q[1], col_q[2], w_new};
        out_idx_q   <= i_q[5:2];
        out_last_q  <= last_word;
        out_valid_q <= 1'b1;
      end else if (rk_ready) begin
        out_valid_q <= 1'b0;
      end
    end
  end

  if (STORE_KEYS) begin : g_store
    logic [127:0] store_q [0:MAX_ROUNDS];

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        for (int k = 0; k <= MAX_ROUNDS; k++) store_q[k] <= '0;
      end else if (key_done) begin
        store_q[i_q[5:2]] <= {col_q[0], col_q[1], col_q[2], w_new};
      end
    end

    assign rd_data = (keys_ready_q && (rd_idx <= nr_q)) ? store_q[rd_idx] : '0;
  end else begin : g_no_store
    assign rd_data = '0;
  end

  assign start_ready = start_ready_w;
  assign busy        = busy_w;
  assign rk_valid    = out_valid_q;
  assign rk_data     = out_data_q;
  assign rk_idx      = out_idx_q;
  assign rk_last     = out_last_q;
  assign keys_ready  = keys_ready_q;
  assign cfg_err     = cfg_err_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_aes_key_expand.sv
// Bench for aes_key_expand: reference key schedule built from GF(2^8) arithmetic,
// expected round keys queued at start, a negedge monitor pops and compares.
module tb_aes_key_expand;

  logic         clk, rst;
  logic [255:0] key_in;
  logic [1:0]   key_len;
  logic         start_valid, start_ready;
  logic         rk_valid, rk_ready;
  logic [127:0] rk_data;
  logic [3:0]   rk_idx;
  logic         rk_last, busy, keys_ready, cfg_err;
  logic [3:0]   rd_idx;
  logic [127:0] rd_data;
  logic [1:0]   dbg_state;

  int tests_run = 0;
  int tests_failed = 0;
  bit ready_mode = 0;

  logic [132:0] exp_q[$];
  logic [7:0]   sb [256];
  logic [31:0]  mw [60];

  localparam logic [255:0] K128 = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
  localparam logic [255:0] K192 = {192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b, 64'h0};
  localparam logic [255:0] K256 = 256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  aes_key_expand #(.MAX_KEY_BITS(256), .STORE_KEYS(1'b1)) dut (
    .clk(clk), .rst(rst), .key_in(key_in), .key_len(key_len),
    .start_valid(start_valid), .start_ready(start_ready),
    .rk_valid(rk_valid), .rk_ready(rk_ready), .rk_data(rk_data), .rk_idx(rk_idx),
    .rk_last(rk_last), .busy(busy), .keys_ready(keys_ready), .cfg_err(cfg_err),
    .rd_idx(rd_idx), .rd_data(rd_data), .dbg_state(dbg_state)
  );

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d failed=%0d", tests_run, tests_failed);
    $fatal(1);
  end

  // reference model
  function automatic logic [7:0] gmul(logic [7:0] a, logic [7:0] b);
    logic [7:0] p = 8'h00;
    for (int k = 0; k < 8; k++) begin
      if (b[0]) p = p ^ a;
      a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
      b = b >> 1;
    end
    return p;
  endfunction

  function automatic logic [7:0] rotl8(logic [7:0] x, int n);
    return (x << n) | (x >> (8 - n));
  endfunction

  task automatic build_sbox();
    for (int a = 0; a < 256; a++) begin
      logic [7:0] inv = 8'h00;
      for (int b = 1; b < 256; b++) begin
        if (gmul(8'(a), 8'(b)) == 8'h01) inv = 8'(b);
      end
      sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
    end
  endtask

  function automatic logic [31:0] subw(logic [31:0] w);
    return {sb[w[31:24]], sb[w[23:16]], sb[w[15:8]], sb[w[7:0]]};
  endfunction

  task automatic model_expand(input logic [255:0] k, input int nk);
    int nr = nk + 6;
    logic [7:0] rc = 8'h01;
    for (int i = 0; i < 4 * (nr + 1); i++) begin
      if (i < nk) begin
        mw[i] = k[255 - 32*i -: 32];
      end else begin
        logic [31:0] t = mw[i-1];
        if (i % nk == 0) begin
          t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
          rc = gmul(rc, 8'h02);
        end else if (nk > 6 && i % nk == 4) begin
          t = subw(t);
        end
        mw[i] = mw[i-nk] ^ t;
      end
    end
  endtask

  function automatic logic [127:0] model_key(int r);
    return {mw[4*r], mw[4*r+1], mw[4*r+2], mw[4*r+3]};
  endfunction

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    tests_run++;
    tests_failed++;
    $display("FAIL %s: timed out waiting for the DUT", name);
  endtask

  // rk_ready driver: always ready, or ~30% duty
  initial begin
    rk_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      rk_ready = ready_mode ? ($urandom_range(0, 9) < 3) : 1'b1;
    end
  end

  // scoreboard monitor
  initial begin : monitor
    logic [132:0] cur, hold_v, e;
    bit hold_f;
    hold_f = 0;
    hold_v = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        hold_f = 0;
      end else begin
        cur = {rk_data, rk_idx, rk_last};
        if (hold_f) chk("stall_hold", 136'({rk_valid, cur}), 136'({1'b1, hold_v}));
        if (rk_valid && rk_ready) begin
          if (exp_q.size() == 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL unexpected_key: got idx %0d data %h with nothing expected", rk_idx, rk_data);
          end else begin
            e = exp_q.pop_front();
            chk("round_key", 136'(cur), 136'(e));
          end
        end
        hold_f = rk_valid && !rk_ready;
        hold_v = cur;
      end
    end
  end

  // driver tasks
  task automatic push_expected(input logic [255:0] k, input logic [1:0] kl);
    int nk = 4 + 2 * int'(kl);
    int nr = nk + 6;
    model_expand(k, nk);
    for (int r = 0; r <= nr; r++) exp_q.push_back({model_key(r), 4'(r), (r == nr)});
  endtask

  // Returns at handshake edge + 1.
  task automatic start_key(input logic [255:0] k, input logic [1:0] kl);
    bit got = 0;
    for (int n = 0; n < 3000 && !got; n++) begin
      @(posedge clk);
      #1;
      if (start_ready) got = 1;
    end
    if (!got) begin
      timeout_fail("start_ready");
      return;
    end
    key_in = k;
    key_len = kl;
    start_valid = 1'b1;
    if (kl != 2'd3) push_expected(k, kl);
    @(posedge clk);
    #1;
    start_valid = 1'b0;
  endtask

  task automatic wait_done();
    bit done = 0;
    for (int n = 0; n < 4000 && !done; n++) begin
      @(posedge clk);
      #1;
      if (exp_q.size() == 0 && keys_ready && !busy && start_ready) done = 1;
    end
    if (!done) timeout_fail("expansion_done");
  endtask

  task automatic rd_all(input int nr);
    for (int r = 0; r < 16; r++) begin
      rd_idx = 4'(r);
      #1;
      chk($sformatf("rd_port[%0d]", r), 136'(rd_data), 136'((r <= nr) ? model_key(r) : 128'h0));
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    rd_idx = 4'd0;
    #1;
    chk({tag, "_start_ready"}, 136'(start_ready), 136'(1));
    chk({tag, "_outputs_zero"}, 136'({rk_valid, rk_last, rk_idx, busy, keys_ready, cfg_err, dbg_state}), 136'(0));
    chk({tag, "_rk_data"}, 136'(rk_data), 136'(0));
    chk({tag, "_rd_data"}, 136'(rd_data), 136'(0));
  endtask

  // stimulus
  initial begin
    int cyc;
    bit early, seen;
    rst = 1'b0;
    start_valid = 1'b0;
    key_in = '0;
    key_len = '0;
    rd_idx = '0;
    build_sbox();
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b1;

    // AES-128, always ready: latency and rk_last timing
    start_key(K128, 2'd0);
    cyc = 0;
    while (!rk_valid && cyc < 100) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("first_key_latency", 136'(cyc), 136'(4));
    while (!(rk_valid && rk_last) && cyc < 200) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("last_key_latency", 136'(cyc), 136'(44));
    chk("last_key_idx", 136'(rk_idx), 136'(10));
    @(posedge clk);
    #1;
    chk("done_flags", 136'({busy, keys_ready}), 136'(2'b01));
    wait_done();
    rd_idx = 4'd10;
    #1;
    chk("aes128_vector", 136'(rd_data), 136'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));
    rd_all(10);

    // AES-192
    start_key(K192, 2'd1);
    wait_done();
    rd_idx = 4'd0;
    #1;
    chk("aes192_rd0", 136'(rd_data), 136'(128'h8e73b0f7da0e6452c810f32b809079e5));
    rd_idx = 4'd12;
    #1;
    chk("aes192_vector", 136'(rd_data), 136'(128'he98ba06f448c773c8ecc720401002202));

    // AES-256, then again with 30% backpressure
    start_key(K256, 2'd2);
    wait_done();
    rd_idx = 4'd14;
    #1;
    chk("aes256_vector", 136'(rd_data), 136'(128'hfe4890d1e6188d0b046df344706c631e));
    rd_idx = 4'd15;
    #1;
    chk("aes256_rd15", 136'(rd_data), 136'(0));
    ready_mode = 1;
    start_key(K256, 2'd2);
    wait_done();
    ready_mode = 0;
    rd_all(14);

    // reserved key_len: single cfg_err pulse, store untouched
    start_key(K128, 2'd3);
    chk("cfg_err_pulse", 136'({cfg_err, busy}), 136'(2'b10));
    @(posedge clk);
    #1;
    chk("cfg_err_clear", 136'(cfg_err), 136'(0));
    seen = 0;
    for (int n = 0; n < 10; n++) begin
      if (rk_valid || busy) seen = 1;
      @(posedge clk);
      #1;
    end
    chk("cfg_no_activity", 136'(seen), 136'(0));
    chk("cfg_keys_ready_kept", 136'(keys_ready), 136'(1));
    rd_all(14);

    // start_valid held through a whole expansion
    start_key(K128, 2'd0);
    key_in = K192;
    key_len = 2'd1;
    start_valid = 1'b1;
    early = 0;
    cyc = 0;
    while (!start_ready && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    if (!start_ready) begin
      timeout_fail("held_start");
      start_valid = 1'b0;
    end else begin
      chk("held_not_early", 136'(cyc >= 40), 136'(1));
      chk("held_drained", 136'(exp_q.size()), 136'(0));
      push_expected(K192, 2'd1);
      @(posedge clk);
      #1;
      start_valid = 1'b0;
      chk("held_accepted", 136'(busy), 136'(1));
      wait_done();
      rd_all(12);
    end

    // random keys and lengths
    for (int r = 0; r < 4; r++) begin
      logic [255:0] k;
      logic [1:0] kl;
      for (int w = 0; w < 8; w++) k[32*w +: 32] = $urandom;
      kl = 2'($urandom_range(0, 2));
      ready_mode = 1'($urandom_range(0, 1));
      start_key(k, kl);
      wait_done();
      ready_mode = 0;
      rd_all(10 + 2 * int'(kl));
    end

    // reset in the middle of an AES-192 expansion
    start_key(K192, 2'd1);
    repeat (20) @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check_reset_outputs("midreset");
    @(posedge clk);
    #3;
    rst = 1'b1;
    start_key(K128, 2'd0);
    wait_done();
    rd_idx = 4'd10;
    #1;
    chk("post_reset_vector", 136'(rd_data), 136'(128'hd014f9a8c9ee2589e13f0cc8b6630ca6));

    // final report
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
